// File: rtl/td4_pkg.sv
// Shared types and defaults for the TD4 fetch sequencer.
package td4_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned INST_W_DEF = 8;
  localparam int unsigned RESET_PC   = 0;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec,
    StHalt
  } seq_state_e;

endpackage

// File: rtl/td4_pc.sv
// Program counter: synchronous reset, jump load and increment with natural wrap-around.
module td4_pc import td4_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i;
    end else if (inc_i) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= ADDR_W'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/td4_fetch_seq.sv
// TD4 instruction-cycle sequencer: FETCH/EXEC FSM, instruction register and retire counter.
// Optional single-step debug (HALT state, dbg_* ports) enabled by defining TD4_SEQ_STEP_EN.
module td4_fetch_seq import td4_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned INST_W = INST_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [ADDR_W-1:0] rom_adrs_o,
  input  logic [INST_W-1:0] rom_data_i,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o,
  input  logic              exec_busy_i,
  input  logic              isjump_i,
  input  logic [ADDR_W-1:0] jumpadrs_i,
  output logic [7:0]        retired_o
`ifdef TD4_SEQ_STEP_EN
  ,
  input  logic              dbg_run_i,
  input  logic              dbg_step_i,
  output logic              dbg_halted_o
`endif
);

`ifdef TD4_SEQ_STEP_EN
  localparam seq_state_e ResetState = StHalt;
  logic dbg_halted_q;
`else
  localparam seq_state_e ResetState = StIdle;
`endif

  seq_state_e        state_q;
  logic [INST_W-1:0] ir_q;
  logic              inst_valid_q;
  logic [7:0]        retired_q;
  logic              exec_exit;
  logic [ADDR_W-1:0] pc;

  // Jump inputs only matter on the cycle EXEC actually completes.
  assign exec_exit = (state_q == StExec) && !exec_busy_i;

  td4_pc #(
    .ADDR_W(ADDR_W)
  ) u_pc (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (exec_exit && isjump_i),
    .load_addr_i(jumpadrs_i),
    .inc_i      (exec_exit && !isjump_i),
    .pc_o       (pc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ResetState;
      ir_q         <= '0;
      inst_valid_q <= 1'b0;
      retired_q    <= 8'd0;
`ifdef TD4_SEQ_STEP_EN
      dbg_halted_q <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StFetch;
        end
        StFetch: begin
          ir_q         <= rom_data_i;
          inst_valid_q <= 1'b1;
          state_q      <= StExec;
        end
        StExec: begin
          if (!exec_busy_i) begin
            retired_q    <= retired_q + 8'd1;
            inst_valid_q <= 1'b0;
`ifdef TD4_SEQ_STEP_EN
            if (dbg_run_i) begin
              state_q <= StFetch;
            end else begin
              state_q      <= StHalt;
              dbg_halted_q <= 1'b1;
            end
`else
            state_q <= StFetch;
`endif
          end
        end
        StHalt: begin
`ifdef TD4_SEQ_STEP_EN
          // A step leaves HALT like a run; EXEC exit returns here while dbg_run is low.
          if (dbg_run_i || dbg_step_i) begin
            state_q      <= StFetch;
            dbg_halted_q <= 1'b0;
          end
`else
          state_q <= StIdle;
`endif
        end
        default: begin
          state_q <= ResetState;
        end
      endcase
    end
  end

  assign rom_adrs_o   = pc;
  assign inst_o       = ir_q;
  assign inst_valid_o = inst_valid_q;
  assign retired_o    = retired_q;
`ifdef TD4_SEQ_STEP_EN
  assign dbg_halted_o = dbg_halted_q;
`endif

endmodule

// File: tb/tb_td4_fetch_seq.sv
// Scoreboard bench for td4_fetch_seq: random stall/jump stimulus against an instruction-level model.
module tb_td4_fetch_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rom_adrs;
  logic [7:0] rom_data;
  logic [7:0] inst;
  logic       inst_valid;
  logic       exec_busy = 1'b0;
  logic       isjump = 1'b0;
  logic [3:0] jumpadrs = 4'h0;
  logic [7:0] retired;
`ifdef TD4_SEQ_STEP_EN
  logic       dbg_run = 1'b1;
  logic       dbg_step = 1'b0;
  logic       dbg_halted;
`endif

  logic [7:0] rom [16];
  assign rom_data = rom[rom_adrs];

  always #5 clk = ~clk;

  td4_fetch_seq #(
    .ADDR_W(4),
    .INST_W(8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rom_adrs_o  (rom_adrs),
    .rom_data_i  (rom_data),
    .inst_o      (inst),
    .inst_valid_o(inst_valid),
    .exec_busy_i (exec_busy),
    .isjump_i    (isjump),
    .jumpadrs_i  (jumpadrs),
    .retired_o   (retired)
`ifdef TD4_SEQ_STEP_EN
    ,
    .dbg_run_i   (dbg_run),
    .dbg_step_i  (dbg_step),
    .dbg_halted_o(dbg_halted)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One expected instruction: its IR value, valid length and retire count while in EXEC.
  typedef struct {
    logic [7:0] inst;
    int         nvalid;
    logic [7:0] retired;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_en = 1'b0;
  exp_t cur;
  bit   in_run = 1'b0;
  int   run_len = 0;
  logic [7:0] ret_next;

  always @(negedge clk) begin
    if (!mon_en) begin
      in_run = 1'b0;
    end else if (inst_valid) begin
      if (!in_run) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst: got %0h, required no instruction", inst);
        end else begin
          cur     = exp_q.pop_front();
          in_run  = 1'b1;
          run_len = 0;
        end
      end
      if (in_run) begin
        check("inst", inst, cur.inst);
        check("retired_in_exec", retired, cur.retired);
        run_len++;
      end
    end else if (in_run) begin
      ret_next = cur.retired + 8'd1;
      check("valid_len", run_len, cur.nvalid);
      check("retired_after", retired, ret_next);
      in_run = 1'b0;
    end
  end

  int pc_m = 0;
  int ret_m = 0;

  // Issue one instruction: n busy cycles, then exit with jump j to t. Called at a negedge
  // while the DUT is outside EXEC; returns at the negedge after the exit edge.
  task automatic run_inst(input int n, input bit j, input logic [3:0] t);
    exp_t e;
    int   w;
    e.inst    = rom[pc_m];
    e.nvalid  = n + 1;
    e.retired = 8'(ret_m);
    exp_q.push_back(e);
    w = 0;
    while (!inst_valid && w < 8) begin
      exec_busy = 1'($urandom);
      isjump    = 1'($urandom);
      jumpadrs  = 4'($urandom);
      @(negedge clk);
      w++;
    end
    checks++;
    if (!inst_valid) begin
      errors++;
      $display("FAIL exec_timeout: got inst_valid=0, required 1 within 8 cycles");
      return;
    end
    for (int k = 0; k < n; k++) begin
      exec_busy = 1'b1;
      isjump    = 1'($urandom);
      jumpadrs  = 4'($urandom);
      @(negedge clk);
    end
    exec_busy = 1'b0;
    isjump    = j;
    jumpadrs  = t;
    @(negedge clk);
    pc_m  = j ? int'(t) : (pc_m + 1) % 16;
    ret_m = (ret_m + 1) % 256;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    for (int i = 0; i < 16; i++) rom[i] = 8'h10 + 8'(i);

    repeat (3) @(negedge clk);
    check("reset_rom_adrs", rom_adrs, 0);
    check("reset_inst", inst, 0);
    check("reset_valid", inst_valid, 0);
    check("reset_retired", retired, 0);

`ifdef TD4_SEQ_STEP_EN
    check("reset_halted", dbg_halted, 1);
    dbg_run = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("halt_holds", dbg_halted, 1);
    dbg_step = 1'b1;
    @(negedge clk);
    dbg_step = 1'b0;
    check("step_left_halt", dbg_halted, 0);
    @(negedge clk);
    check("step_valid", inst_valid, 1);
    check("step_inst", inst, 8'h10);
    @(negedge clk);
    check("step_rehalted", dbg_halted, 1);
    check("step_pc", rom_adrs, 1);
    check("step_retired", retired, 1);
    @(negedge clk);
    check("halt_no_valid", inst_valid, 0);
    check("halt_pc_held", rom_adrs, 1);
    dbg_run = 1'b1;
    repeat (2) @(negedge clk);
    check("run_inst", inst, 8'h11);
    rst = 1'b1;
    repeat (2) @(negedge clk);
`endif

    // First instruction timing from reset release.
    exec_busy = 1'b0;
    isjump    = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("c2_valid_low", inst_valid, 0);
    check("c2_rom_adrs", rom_adrs, 0);
    @(negedge clk);
    check("c3_valid_high", inst_valid, 1);
    check("c3_inst", inst, 8'h10);

    // Reset in EXEC at pc = 7 abandons the instruction.
    w = 0;
    while (!(inst_valid && inst == 8'h17) && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("reach_pc7", inst, 8'h17);
    check("pc7_retired", retired, 7);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pc", rom_adrs, 0);
    check("rst_mid_inst", inst, 0);
    check("rst_mid_valid", inst_valid, 0);
    check("rst_mid_retired", retired, 0);
    @(negedge clk);

    // Scoreboarded directed sequence, then random traffic.
    pc_m   = 0;
    ret_m  = 0;
    mon_en = 1'b1;
    rst    = 1'b0;
    for (int i = 0; i < 16; i++) run_inst(0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) run_inst(0, 1'b0, 4'h0);
    run_inst(0, 1'b1, 4'hA);
    run_inst(0, 1'b0, 4'h0);
    run_inst(0, 1'b1, 4'h5);
    run_inst(3, 1'b0, 4'h0);
    run_inst(0, 1'b1, 4'h6);
    run_inst(0, 1'b1, 4'h6);
    run_inst(0, 1'b0, 4'h0);

    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 300; i++) begin
      run_inst(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom));
    end
    mon_en = 1'b0;
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/td4_fetch_seq.md
# td4_fetch_seq

Instruction-cycle sequencer for the 4-bit TD4-style core. It owns the program counter and drives the instruction ROM address. It latches each 8-bit instruction and presents it to the execute stage with a valid strobe. It also applies jump requests coming back from execute, and sits between the instruction ROM and the decode/execute logic in place of a free-running fetch.

## Interface
- ADDR_W, 4, PC / ROM address width
- INST_W, 8, instruction width
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rom_adrs  out  ADDR_W  ROM address, equals PC register
- rom_data  in  INST_W  ROM read data, combinational from rom_adrs
- inst  out  INST_W  latched instruction register (IR)
- inst_valid  out  1  high for every cycle in EXEC
- exec_busy  in  1  execute stage not finished; holds EXEC
- isjump  in  1  jump taken, sampled only on EXEC exit
- jumpadrs  in  ADDR_W  jump target, sampled with isjump
- retired  out  8  count of completed instructions, wraps 255->0
- dbg_run, dbg_step in 1; dbg_halted out 1 — present only with TD4_SEQ_STEP_EN

## Operation
- FSM states: IDLE, FETCH, EXEC, HALT (HALT reachable only with TD4_SEQ_STEP_EN).
- IDLE -> FETCH unconditionally (without macro); one bubble cycle after reset.
- FETCH: rom_adrs = pc; at edge IR <= rom_data, -> EXEC.
- EXEC: inst_valid = 1, inst = IR stable.
  - If exec_busy = 1, stay in EXEC; pc, IR, retired frozen.
  - If exec_busy = 0, leave EXEC: pc <= isjump ? jumpadrs : pc + 1 (mod 2^ADDR_W, 15 -> 0), retired <= retired + 1, -> FETCH.
- isjump/jumpadrs ignored in every state and cycle except the EXEC exit cycle. A jump to the current pc is legal and refetches the same address.
- Reset mid-instruction (any state): abandon the instruction; the retired count is not incremented.

## Timing
- Reset values: pc = 0, rom_adrs = 0, IR/inst = 8'h00, inst_valid = 0, retired = 0, state IDLE (HALT with macro), dbg_halted = 1 (with macro).
- Unstalled throughput: 2 cycles per instruction (FETCH, EXEC).
- First edge with rst = 0: IDLE -> FETCH. Next edge: IR loaded from ROM[0]. inst_valid goes high in the third cycle after reset release.
- rom_data must be valid within FETCH cycle; there are no ROM wait states.
- inst changes only on the FETCH -> EXEC edge; it stays stable while inst_valid = 0.

## Configuration
- Macro TD4_SEQ_STEP_EN.
- Defined:
  - Debug ports exist; reset enters HALT. HALT holds pc/IR, inst_valid = 0, dbg_halted = 1.
  - In HALT, dbg_run = 1 -> FETCH.
  - In HALT, a dbg_step = 1 cycle runs exactly one FETCH+EXEC, then returns to HALT.
  - On EXEC exit with dbg_run = 0, go to HALT instead of FETCH; pc update still occurs.
  - dbg_run and dbg_step both high: dbg_run wins.
  - IDLE unused.
- Undefined: no debug ports; HALT never entered; free-running from IDLE.

## Structure
- Shared package td4_pkg: state enum (IDLE, FETCH, EXEC, HALT), ADDR_W/INST_W defaults, RESET_PC = 0.
- One sub-module td4_pc: PC register with synchronous reset, load (jump) and increment enables, wrap-around. The FSM, IR and retired counter stay in the top.

## Test plan
- ROM[i] = 8'h10+i, no jumps, no stall, rst released -> inst 10,11,12,… one every 2 cycles; first inst_valid 3rd cycle after release.
- Run 16 instructions -> pc wraps 15 -> 0, inst returns to 8'h10, retired = 16.
- At pc = 3, isjump = 1 with jumpadrs = 4'hA -> next inst = ROM[10] = 8'h1A. isjump pulsed during FETCH -> ignored.
- exec_busy high 3 cycles in EXEC at pc = 5 -> inst_valid held 4 cycles, inst = 8'h15 stable, retired increments once.
- rst asserted during EXEC at pc = 7 -> next cycle pc = 0, inst = 00, inst_valid = 0, retired = 0.
- With TD4_SEQ_STEP_EN: reset -> dbg_halted = 1. One dbg_step pulse -> single inst 8'h10, pc = 1, back in HALT. dbg_run = 1 -> free-running from pc = 1.
